// File: rtl/control_if.sv
// control_if: decode bus between the instruction fetch side and the main
// control unit.
//   opcode     4  instruction opcode field (fetch -> control)
//   alu_op     2  ALU class: 00 add, 01 sub/compare, 10 R-type, 11 AND-imm
//   reg_dst    1  destination register from rd (1) or rt (0)
//   beq        1  branch-if-equal instruction
//   reg_write  1  register-file write enable
//   jump       1  unconditional jump
//   alu_src    1  ALU operand B is the sign-extended immediate
//   mem_to_reg 1  write-back data comes from data memory
//   mem_read   1  data-memory read enable
//   mem_write  1  data-memory write enable
//   illegal_op 1  sticky undefined-opcode flag (only with CONTROL_ILLEGAL_TRAP_EN)
// Modports: master = opcode source / decode consumer, slave = control unit.
interface control_if;
  logic [3:0] opcode;
  logic [1:0] alu_op;
  logic       reg_dst;
  logic       beq;
  logic       reg_write;
  logic       jump;
  logic       alu_src;
  logic       mem_to_reg;
  logic       mem_read;
  logic       mem_write;
`ifdef CONTROL_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  modport master (
`ifdef CONTROL_ILLEGAL_TRAP_EN
    input  illegal_op,
`endif
    output opcode,
    input  alu_op, reg_dst, beq, reg_write, jump,
    input  alu_src, mem_to_reg, mem_read, mem_write
  );

  modport slave (
`ifdef CONTROL_ILLEGAL_TRAP_EN
    output illegal_op,
`endif
    input  opcode,
    output alu_op, reg_dst, beq, reg_write, jump,
    output alu_src, mem_to_reg, mem_read, mem_write
  );
endinterface

// File: rtl/control.sv
// control: main control unit. Decodes the 4-bit opcode into datapath
// control strobes; every output is a flop, so a decode appears one clock
// after its opcode is sampled and is glitch-free.
// Ports:
//   clk    1  rising-edge clock
//   reset  1  synchronous active-high; clears all output registers
//   bus    control_if.slave (opcode in, decoded strobes out)
// Optional feature macro: CONTROL_ILLEGAL_TRAP_EN adds a sticky illegal_op
// flag set by any opcode in 8-15. Without it, 8-15 decode as NOP.
module control (
  input  logic      clk,
  input  logic      reset,
  control_if.slave  bus
);

  logic [1:0] w_alu_op;
  logic       w_reg_dst;
  logic       w_beq;
  logic       w_reg_write;
  logic       w_jump;
  logic       w_alu_src;
  logic       w_mem_to_reg;
  logic       w_mem_read;
  logic       w_mem_write;

  logic [1:0] r_alu_op;
  logic       r_reg_dst;
  logic       r_beq;
  logic       r_reg_write;
  logic       r_jump;
  logic       r_alu_src;
  logic       r_mem_to_reg;
  logic       r_mem_read;
  logic       r_mem_write;

  // Combinational decode. Everything defaults to the NOP pattern, so
  // opcodes 7-15 fall through with no write enables asserted.
  always_comb begin
    w_alu_op     = 2'b00;
    w_reg_dst    = 1'b0;
    w_beq        = 1'b0;
    w_reg_write  = 1'b0;
    w_jump       = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    case (bus.opcode)
      4'd0: begin // R-type
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        w_alu_op    = 2'b10;
      end
      4'd1: begin // ADDI
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      4'd2: begin // LW
        w_alu_src    = 1'b1;
        w_mem_to_reg = 1'b1;
        w_mem_read   = 1'b1;
        w_reg_write  = 1'b1;
      end
      4'd3: begin // SW
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      4'd4: begin // BEQ
        w_beq    = 1'b1;
        w_alu_op = 2'b01;
      end
      4'd5: begin // J
        w_jump = 1'b1;
      end
      4'd6: begin // ANDI
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_alu_op    = 2'b11;
      end
      default: ; // NOP and undefined opcodes
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_op     <= 2'b00;
      r_reg_dst    <= 1'b0;
      r_beq        <= 1'b0;
      r_reg_write  <= 1'b0;
      r_jump       <= 1'b0;
      r_alu_src    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else begin
      r_alu_op     <= w_alu_op;
      r_reg_dst    <= w_reg_dst;
      r_beq        <= w_beq;
      r_reg_write  <= w_reg_write;
      r_jump       <= w_jump;
      r_alu_src    <= w_alu_src;
      r_mem_to_reg <= w_mem_to_reg;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
    end
  end

  assign bus.alu_op     = r_alu_op;
  assign bus.reg_dst    = r_reg_dst;
  assign bus.beq        = r_beq;
  assign bus.reg_write  = r_reg_write;
  assign bus.jump       = r_jump;
  assign bus.alu_src    = r_alu_src;
  assign bus.mem_to_reg = r_mem_to_reg;
  assign bus.mem_read   = r_mem_read;
  assign bus.mem_write  = r_mem_write;

`ifdef CONTROL_ILLEGAL_TRAP_EN
  logic r_illegal_op;

  // Opcodes 8-15 are exactly those with the MSB set; once seen, the flag
  // holds until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_illegal_op <= 1'b0;
    end else begin
      r_illegal_op <= r_illegal_op | bus.opcode[3];
    end
  end

  assign bus.illegal_op = r_illegal_op;
`endif

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: directed vector table, hand-written
// multi-cycle sequences and randomized opcodes against a set-based model.
module tb_control;

  logic clk;
  logic reset;
  control_if u_if ();

  control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
`ifdef CONTROL_ILLEGAL_TRAP_EN
  logic exp_ill = 1'b0;
`endif

  // Packed order: {alu_op[1:0], reg_dst, beq, reg_write, jump,
  //                alu_src, mem_to_reg, mem_read, mem_write}
  localparam logic [9:0] D_R    = 10'b10_1_0_1_0_0_0_0_0;
  localparam logic [9:0] D_ADDI = 10'b00_0_0_1_0_1_0_0_0;
  localparam logic [9:0] D_LW   = 10'b00_0_0_1_0_1_1_1_0;
  localparam logic [9:0] D_SW   = 10'b00_0_0_0_0_1_0_0_1;
  localparam logic [9:0] D_BEQ  = 10'b01_0_1_0_0_0_0_0_0;
  localparam logic [9:0] D_J    = 10'b00_0_0_0_1_0_0_0_0;
  localparam logic [9:0] D_ANDI = 10'b11_0_0_1_0_1_0_0_0;
  localparam logic [9:0] D_NONE = 10'b00_0_0_0_0_0_0_0_0;

  // Reference model built from per-signal opcode sets.
  function automatic logic [9:0] model(input logic [3:0] op);
    logic [1:0] aop;
    logic rd, bq, rw, jp, as, mr2, mrd, mwr;
    rd  = (op == 4'd0);
    bq  = (op == 4'd4);
    rw  = (op inside {4'd0, 4'd1, 4'd2, 4'd6});
    jp  = (op == 4'd5);
    as  = (op inside {4'd1, 4'd2, 4'd3, 4'd6});
    mr2 = (op == 4'd2);
    mrd = (op == 4'd2);
    mwr = (op == 4'd3);
    aop = (op == 4'd0) ? 2'b10 : (op == 4'd4) ? 2'b01 :
          (op == 4'd6) ? 2'b11 : 2'b00;
    return {aop, rd, bq, rw, jp, as, mr2, mrd, mwr};
  endfunction

  function automatic logic [9:0] actual();
    return {u_if.alu_op, u_if.reg_dst, u_if.beq, u_if.reg_write, u_if.jump,
            u_if.alu_src, u_if.mem_to_reg, u_if.mem_read, u_if.mem_write};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 ns after the capturing edge.
  task automatic step(input logic r, input logic [3:0] op, input logic [9:0] exp,
                      input string name);
    logic [9:0] a;
    logic inv_ok;
    reset = r;
    u_if.opcode = op;
    @(posedge clk);
    #1;
    a = actual();
    check(name, a, exp);
    inv_ok = !(u_if.mem_read && u_if.mem_write) && !(u_if.beq && u_if.jump) &&
             (!u_if.mem_to_reg || u_if.mem_read) && (!u_if.reg_dst || u_if.reg_write);
    check({name, "_inv"}, {9'd0, inv_ok}, 10'd1);
`ifdef CONTROL_ILLEGAL_TRAP_EN
    exp_ill = r ? 1'b0 : (exp_ill | (op >= 4'd8));
    check({name, "_ill"}, {9'd0, u_if.illegal_op}, {9'd0, exp_ill});
`endif
    $display("step rst=%0d op=%0d out=%b exp=%b", r, op, a, exp);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] op;
    int         hold;
    logic [9:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset = 1'b1;
    u_if.opcode = 4'd0;

    // Directed table
    vecs.push_back('{1'b1, 4'd2, 4, D_NONE, "reset_hold"});
    vecs.push_back('{1'b0, 4'd2, 1, D_LW,   "first_after_reset"});
    vecs.push_back('{1'b0, 4'd0, 10, D_R,    "sweep0"});
    vecs.push_back('{1'b0, 4'd1, 10, D_ADDI, "sweep1"});
    vecs.push_back('{1'b0, 4'd2, 10, D_LW,   "sweep2"});
    vecs.push_back('{1'b0, 4'd3, 10, D_SW,   "sweep3"});
    vecs.push_back('{1'b0, 4'd4, 10, D_BEQ,  "sweep4"});
    vecs.push_back('{1'b0, 4'd5, 10, D_J,    "sweep5"});
    vecs.push_back('{1'b0, 4'd6, 10, D_ANDI, "sweep6"});
    vecs.push_back('{1'b0, 4'd7, 10, D_NONE, "sweep7"});
    vecs.push_back('{1'b0, 4'd8, 10, D_NONE, "sweep8"});
    vecs.push_back('{1'b0, 4'd3, 1, D_SW,   "sw_then"});
    vecs.push_back('{1'b0, 4'd4, 1, D_BEQ,  "beq_no_bubble"});
    vecs.push_back('{1'b0, 4'd5, 1, D_J,    "jump_only"});
    vecs.push_back('{1'b0, 4'd0, 1, D_R,    "rtype"});
    vecs.push_back('{1'b0, 4'd15, 1, D_NONE, "op15"});

    for (int i = 0; i < vecs.size(); i++)
      for (int k = 0; k < vecs[i].hold; k++)
        step(vecs[i].rst, vecs[i].op, vecs[i].exp, vecs[i].name);

    // Mid-stream reset discards the pending decode.
    step(1'b0, 4'd6, D_ANDI, "pre_reset");
    step(1'b1, 4'd2, D_NONE, "mid_reset");
    step(1'b0, 4'd1, D_ADDI, "post_reset");

`ifdef CONTROL_ILLEGAL_TRAP_EN
    // Sticky illegal flag: set by 12, kept by 1, cleared by reset.
    step(1'b0, 4'd12, D_NONE, "ill_12");
    check("ill_set", {9'd0, u_if.illegal_op}, 10'd1);
    step(1'b0, 4'd1, D_ADDI, "ill_keep");
    check("ill_sticky", {9'd0, u_if.illegal_op}, 10'd1);
    step(1'b1, 4'd1, D_NONE, "ill_reset");
    check("ill_clear", {9'd0, u_if.illegal_op}, 10'd0);
`endif

    // Exhaustive opcode walk against the model.
    for (int op = 0; op < 16; op++)
      step(1'b0, 4'(op), model(4'(op)), "exhaustive");

    // Randomized opcodes with occasional reset.
    for (int i = 0; i < 300; i++) begin
      logic r;
      logic [3:0] op;
      r  = ($urandom_range(0, 19) == 0);
      op = 4'($urandom_range(0, 15));
      step(r, op, r ? D_NONE : model(op), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
